// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) instruction decoder with registered ID/EX control bundle.
// A small occupancy FSM holds EX and raises busy_o while a MUL/DIV is in flight.
module decode_ctrl_stage #(
  parameter int unsigned MULDIV_EN  = 1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        e_valid_o,
  output logic        e_RegWrite_o,
  output logic        e_ALUSrc_o,
  output logic        e_MemWrite_o,
  output logic        e_Jump_o,
  output logic        e_Jalr_o,
  output logic        e_Branch_o,
  output logic        e_lui_o,
  output logic [2:0]  e_ImmSrc_o,
  output logic [1:0]  e_ResultSrc_o,
  output logic [1:0]  e_ALUOp_o,
  output logic [2:0]  e_funct3_o,
  output logic        e_funct7b5_o,
  output logic        e_muldiv_o,
  output logic        e_illegal_o
);

  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       lui;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       muldiv;
    logic       illegal;
  } ex_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_t              ex_q, ex_d;
  ex_t              dec;
  logic             legal;
  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [CNT_W-1:0] md_lat;
  logic             accept;
  logic             unused_bits;

  assign opcode      = instr_i[6:0];
  assign funct7      = instr_i[31:25];
  assign md_lat      = instr_i[14] ? DIV_N : MUL_N;
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      7'b0000011: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      7'b0100011: begin
        dec.imm_src   = 3'b001;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          legal = 1'b1;
        end else if (funct7 == 7'b0000001 && MULDIV_EN != 0) begin
          dec.muldiv = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      7'b1100011: begin
        dec.imm_src = 3'b010;
        dec.alu_op  = 2'b01;
        dec.branch  = 1'b1;
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      7'b1101111: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b011;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
      7'b1100111: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jalr       = 1'b1;
      end
      7'b0110111: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b100;
        dec.result_src = 2'b11;
        dec.lui        = 1'b1;
      end
      7'b0010111: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b100;
        dec.result_src = 2'b11;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      dec.valid    = 1'b1;
      dec.funct3   = instr_i[14:12];
      dec.funct7b5 = instr_i[30];
    end else begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  // The BUSY release edge (cnt=1) doubles as an acceptance edge, so
  // back-to-back ops see no dead cycle.
  assign accept = (state_q == IDLE) || flush_i || (cnt_q == ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    if (!accept) begin
      cnt_d = cnt_q - ONE;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      if (flush_i || stall_i || !valid_i) begin
        ex_d = '0;
      end else begin
        ex_d = dec;
        if (dec.muldiv && (md_lat > ONE)) begin
          cnt_d   = md_lat - ONE;
          state_d = BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign busy_o        = (state_q == BUSY);
  assign e_valid_o     = ex_q.valid;
  assign e_RegWrite_o  = ex_q.reg_write;
  assign e_ImmSrc_o    = ex_q.imm_src;
  assign e_ALUSrc_o    = ex_q.alu_src;
  assign e_MemWrite_o  = ex_q.mem_write;
  assign e_ResultSrc_o = ex_q.result_src;
  assign e_ALUOp_o     = ex_q.alu_op;
  assign e_Jump_o      = ex_q.jump;
  assign e_Jalr_o      = ex_q.jalr;
  assign e_Branch_o    = ex_q.branch;
  assign e_lui_o       = ex_q.lui;
  assign e_funct3_o    = ex_q.funct3;
  assign e_funct7b5_o  = ex_q.funct7b5;
  assign e_muldiv_o    = ex_q.muldiv;
  assign e_illegal_o   = ex_q.illegal;

endmodule
